ptr_pool: RTL

PTR_POOL -- requirements
Module: ptr_pool

---
 rtl/ptr_pool_pkg.sv | 12 +
 rtl/ptr_pool_ram.sv | 28 ++
 rtl/ptr_pool.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ptr_pool_pkg.sv
// Shared types and default constants for the pointer pool.
package ptr_pool_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_PTR_WIDTH = 10;
    localparam int DEF_LOW_WM    = 4;

endpackage

// File: rtl/ptr_pool_ram.sv
// Circular pointer store: one write port, one registered read port.
// The read data register doubles as the pool's prefetch output register.
module ptr_pool_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/ptr_pool.sv
// Free-pointer pool: fills itself with 0..NUM_PTRS-1, then hands pointers out FIFO.
// Optional in-use bitmap for double-free rejection: PTR_POOL_DOUBLE_FREE_CHECK_EN.
module ptr_pool
    import ptr_pool_pkg::*;
#(
    parameter int PTR_WIDTH = DEF_PTR_WIDTH,
    parameter int NUM_PTRS  = 2**PTR_WIDTH,
    parameter int LOW_WM    = DEF_LOW_WM
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 alloc_valid,
    input  logic                 alloc_ready,
    output logic [PTR_WIDTH-1:0] alloc_ptr,
    input  logic                 rel_valid,
    output logic                 rel_ready,
    input  logic [PTR_WIDTH-1:0] rel_ptr,
    output logic                 init_done,
    output logic [PTR_WIDTH:0]   free_count,
    output logic                 low_wm,
    output logic                 err_range,
    output logic                 err_double_free
);

    localparam int                RAM_AW   = $clog2(NUM_PTRS);
    localparam logic [PTR_WIDTH:0] NUM_C   = (PTR_WIDTH+1)'(NUM_PTRS);
    localparam logic [PTR_WIDTH:0] LOW_C   = (PTR_WIDTH+1)'(LOW_WM);
    localparam logic [PTR_WIDTH:0] CNT_ONE = (PTR_WIDTH+1)'(1);
    localparam logic [RAM_AW-1:0]  LAST_IDX = RAM_AW'(NUM_PTRS-1);
    localparam logic [RAM_AW-1:0]  IDX_ONE  = RAM_AW'(1);

    state_t               r_state;
    logic [RAM_AW-1:0]    r_wr_idx;
    logic [RAM_AW-1:0]    r_rd_idx;
    logic [PTR_WIDTH:0]   r_free_count;
    logic                 r_init_done;
    logic                 r_out_valid;
    logic                 r_err_range;

    logic [PTR_WIDTH:0]   w_ram_cnt;
    logic                 w_alloc_xfer;
    logic                 w_rel_acc;
    logic                 w_range_bad;
    logic                 w_dbl_bad;
    logic                 w_rel_ok;
    logic                 w_rd_en;
    logic                 w_wr_en;
    logic [PTR_WIDTH-1:0] w_wr_data;
    logic [PTR_WIDTH-1:0] w_rd_data;

    // free_count includes the pointer parked in the output register
    assign w_ram_cnt    = r_free_count - {{PTR_WIDTH{1'b0}}, r_out_valid};
    assign w_alloc_xfer = r_out_valid && alloc_ready;
    assign rel_ready    = r_init_done && (r_free_count < NUM_C);
    assign w_rel_acc    = rel_valid && rel_ready;
    assign w_range_bad  = ({1'b0, rel_ptr} >= NUM_C);
    assign w_rel_ok     = w_rel_acc && !w_range_bad && !w_dbl_bad;
    assign w_rd_en      = (r_state == ST_RUN) && (w_ram_cnt != '0) && (!r_out_valid || w_alloc_xfer);
    assign w_wr_en      = (r_state == ST_INIT) || w_rel_ok;
    assign w_wr_data    = (r_state == ST_INIT) ? PTR_WIDTH'(r_wr_idx) : rel_ptr;

    assign alloc_valid = r_out_valid;
    assign alloc_ptr   = w_rd_data;
    assign init_done   = r_init_done;
    assign free_count  = r_free_count;
    assign low_wm      = (r_free_count <= LOW_C);
    assign err_range   = r_err_range;

    ptr_pool_ram #(
        .DEPTH (NUM_PTRS),
        .AW    (RAM_AW),
        .DW    (PTR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_free_count <= '0;
            r_init_done  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err_range  <= 1'b0;
        end else begin
            r_err_range <= w_rel_acc && w_range_bad;
            case (r_state)
                ST_INIT: begin
                    r_free_count <= r_free_count + CNT_ONE;
                    if (r_wr_idx == LAST_IDX) begin
                        r_wr_idx    <= '0;
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_wr_idx <= r_wr_idx + IDX_ONE;
                    end
                end
                ST_RUN: begin
                    if (w_rel_ok) begin
                        r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_ONE;
                    end
                    if (w_rd_en) begin
                        r_rd_idx    <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_ONE;
                        r_out_valid <= 1'b1;
                    end else if (w_alloc_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_rel_ok && !w_alloc_xfer) begin
                        r_free_count <= r_free_count + CNT_ONE;
                    end else if (!w_rel_ok && w_alloc_xfer) begin
                        r_free_count <= r_free_count - CNT_ONE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

`ifdef PTR_POOL_DOUBLE_FREE_CHECK_EN
    logic [NUM_PTRS-1:0] r_in_use;
    logic [NUM_PTRS-1:0] w_in_use_next;
    logic [NUM_PTRS-1:0] w_rel_hit;
    logic                r_err_dbl;

    genvar gi;
    for (gi = 0; gi < NUM_PTRS; gi++) begin : g_in_use
        assign w_rel_hit[gi]     = (rel_ptr == PTR_WIDTH'(gi));
        assign w_in_use_next[gi] = (w_alloc_xfer && (alloc_ptr == PTR_WIDTH'(gi))) ? 1'b1 :
                                   (w_rel_ok && w_rel_hit[gi])                       ? 1'b0 :
                                   r_in_use[gi];
    end

    // A pointer that is not marked in use is already sitting in the pool
    assign w_dbl_bad       = !w_range_bad && ((w_rel_hit & r_in_use) == '0);
    assign err_double_free = r_err_dbl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_use  <= '0;
            r_err_dbl <= 1'b0;
        end else begin
            r_err_dbl <= w_rel_acc && w_dbl_bad;
            r_in_use  <= (r_state == ST_INIT) ? '0 : w_in_use_next;
        end
    end
`else
    assign w_dbl_bad       = 1'b0;
    assign err_double_free = 1'b0;
`endif

endmodule
